seg7_monitor: RTL and testbench

- Receive-side checker for a 7-segment digit bus: samples an asynchronous segment pattern, filters glitches, and decodes the pattern back to a BCD digit.
- Verifies that accepted digits advance in a modulo counting sequence and counts errors.
- Sits on input pins, typically looped back from a seg7-driven display bus, as an on-chip self-test and observation point.

---
 rtl/seg7_monitor.sv | 152 +++++++++++++++
 tb/tb_seg7_monitor.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_monitor.sv
// seg7_monitor
//   Receive-side checker for a 7-segment digit bus. The asynchronous segment
//   pattern is synchronized, filtered for stability, decoded back to a BCD
//   digit, and checked against a modulo counting sequence.
//
//   Ports
//     clk          clock
//     reset        synchronous, active-high reset
//     seg_in[6:0]  segment pattern {g,f,e,d,c,b,a}, active-high, asynchronous
//     clear        synchronous clear of err_count only
//     digit[3:0]   last accepted legal digit
//     digit_valid  one-cycle pulse: new pattern accepted and is a legal digit
//     pattern_err  one-cycle pulse: accepted pattern is not a legal digit
//     seq_err      one-cycle pulse: accepted legal digit was not the expected one
//     locked       high while the sequence reference is held
//     err_count    saturating count of pattern_err + seq_err events
module seg7_monitor #(
   parameter int STABLE_CYCLES = 4,
   parameter int WRAP_DIGIT    = 8,
   parameter int ERR_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       seg_in,
   input  logic             clear,
   output logic [3:0]       digit,
   output logic             digit_valid,
   output logic             pattern_err,
   output logic             seq_err,
   output logic             locked,
   output logic [ERR_W-1:0] err_count
);

   typedef enum logic {ACQUIRE, LOCKED} state_t;

   // Segment patterns for digits 0..9, indexed by digit value.
   localparam logic [6:0] SEG_TABLE [10] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   // The run counter reads N-1 once the pattern has been seen for N
   // consecutive cycles, so acceptance compares against STABLE_CYCLES-1.
   localparam logic [7:0] ACCEPT_CNT = 8'(STABLE_CYCLES - 1);

   logic [6:0]       sync1_reg, sync2_reg, prev_reg, last_pat_reg;
   logic             last_valid_reg;
   logic [7:0]       stable_cnt_reg;
   state_t           state_reg;
   logic [3:0]       expected_reg;
   logic [3:0]       digit_reg;
   logic             digit_valid_reg, pattern_err_reg, seq_err_reg;
   logic [ERR_W-1:0] err_count_reg;

   logic [9:0]       match;
   logic             dec_legal;
   logic [3:0]       dec_digit;
   logic             same_next;
   logic             accept;
   logic             out_of_seq;
   logic             err_event;

   function automatic logic [3:0] next_digit(input logic [3:0] d);
      // Digits above the wrap point are legal but restart the sequence at 0.
      return (d >= 4'(WRAP_DIGIT)) ? 4'd0 : d + 4'd1;
   endfunction

   // One comparator per legal digit pattern.
   generate
      for (genvar gi = 0; gi < 10; gi++) begin : g_match
         assign match[gi] = (sync2_reg == SEG_TABLE[gi]);
      end
   endgenerate

   always_comb begin
      dec_legal = 1'b0;
      dec_digit = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (match[i]) begin
            dec_legal = 1'b1;
            dec_digit = 4'(i);
         end
      end
   end

   assign same_next  = (sync2_reg == prev_reg);
   // A held pattern is taken once; the last-accepted marker blocks repeats
   // while the counter stays saturated.
   assign accept     = same_next && (stable_cnt_reg >= ACCEPT_CNT) &&
                       (!last_valid_reg || (sync2_reg != last_pat_reg));
   assign out_of_seq = (state_reg == LOCKED) && (dec_digit != expected_reg);
   assign err_event  = accept && (!dec_legal || out_of_seq);

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_reg       <= '0;
         sync2_reg       <= '0;
         prev_reg        <= '0;
         stable_cnt_reg  <= '0;
         last_valid_reg  <= 1'b0;
         last_pat_reg    <= '0;
         state_reg       <= ACQUIRE;
         expected_reg    <= '0;
         digit_reg       <= '0;
         digit_valid_reg <= 1'b0;
         pattern_err_reg <= 1'b0;
         seq_err_reg     <= 1'b0;
         err_count_reg   <= '0;
      end else begin
         sync1_reg <= seg_in;
         sync2_reg <= sync1_reg;
         prev_reg  <= sync2_reg;

         if (!same_next)
            stable_cnt_reg <= '0;
         else if (stable_cnt_reg != 8'hFF)
            stable_cnt_reg <= stable_cnt_reg + 8'd1;

         digit_valid_reg <= 1'b0;
         pattern_err_reg <= 1'b0;
         seq_err_reg     <= 1'b0;

         if (accept) begin
            last_valid_reg <= 1'b1;
            last_pat_reg   <= sync2_reg;
            if (dec_legal) begin
               digit_valid_reg <= 1'b1;
               seq_err_reg     <= out_of_seq;
               digit_reg       <= dec_digit;
               expected_reg    <= next_digit(dec_digit);
               state_reg       <= LOCKED;
            end else begin
               pattern_err_reg <= 1'b1;
               state_reg       <= ACQUIRE;
            end
         end

         // Counter moves on the same edge that raises the error pulse.
         if (clear)
            err_count_reg <= '0;
         else if (err_event && (err_count_reg != {ERR_W{1'b1}}))
            err_count_reg <= err_count_reg + ERR_W'(1);
      end
   end

   assign digit       = digit_reg;
   assign digit_valid = digit_valid_reg;
   assign pattern_err = pattern_err_reg;
   assign seq_err     = seq_err_reg;
   assign locked      = (state_reg == LOCKED);
   assign err_count   = err_count_reg;

endmodule

// File: tb/tb_seg7_monitor.sv
// tb_seg7_monitor
//   Directed table of segment phases with hand-computed expectations, a few
//   hand-written multi-cycle sequences, and a randomized phase. Every cycle is
//   also compared against a behavioural model: a pattern is taken when the
//   last STABLE+1 input samples, seen two cycles late, all agree and differ
//   from the previously taken pattern. A second instance with a 2-bit error
//   counter shares all inputs.
module tb_seg7_monitor;

   localparam int STABLE = 4;
   localparam int WRAP   = 8;

   localparam logic [6:0] PAT [10] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] seg_in = 7'h00;
   logic       clear = 1'b0;

   logic [3:0] digit, digit2;
   logic       digit_valid, pattern_err, seq_err, locked;
   logic       digit_valid2, pattern_err2, seq_err2, locked2;
   logic [7:0] err_count;
   logic [1:0] err_count2;

   always #5 clk = ~clk;

   seg7_monitor #(.STABLE_CYCLES(STABLE), .WRAP_DIGIT(WRAP), .ERR_W(8)) u_dut (
      .clk(clk), .reset(reset), .seg_in(seg_in), .clear(clear),
      .digit(digit), .digit_valid(digit_valid), .pattern_err(pattern_err),
      .seq_err(seq_err), .locked(locked), .err_count(err_count)
   );

   seg7_monitor #(.STABLE_CYCLES(STABLE), .WRAP_DIGIT(WRAP), .ERR_W(2)) u_dut2 (
      .clk(clk), .reset(reset), .seg_in(seg_in), .clear(clear),
      .digit(digit2), .digit_valid(digit_valid2), .pattern_err(pattern_err2),
      .seq_err(seq_err2), .locked(locked2), .err_count(err_count2)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int hist[$];
   bit m_last_valid;
   int m_last_pat;
   bit m_locked;
   int m_exp, m_digit;
   bit m_dv, m_pe, m_se;
   int m_err8, m_err2;

   function automatic int decode(input int p);
      for (int i = 0; i < 10; i++)
         if (p == int'(PAT[i])) return i;
      return -1;
   endfunction

   task automatic model_update(input logic [6:0] seg, input logic rst, input logic clr);
      int k, lo, v, d;
      bit acc;
      if (rst) begin
         // Synchronizer and history registers hold zero; anything older is unknown.
         hist = '{-1, 0, 0, 0};
         m_last_valid = 0; m_last_pat = 0; m_locked = 0; m_exp = 0; m_digit = 0;
         m_dv = 0; m_pe = 0; m_se = 0; m_err8 = 0; m_err2 = 0;
         return;
      end
      hist.push_back(int'(seg));
      while (hist.size() > STABLE + 8) void'(hist.pop_front());
      m_dv = 0; m_pe = 0; m_se = 0;
      k   = hist.size() - 1;
      lo  = k - 2 - STABLE;
      acc = 0;
      if (lo >= 0) begin
         v   = hist[k-2];
         acc = (v >= 0);
         for (int i = lo; i <= k - 2; i++)
            if (hist[i] != v) acc = 0;
         if (m_last_valid && m_last_pat == v) acc = 0;
      end
      if (acc) begin
         m_last_valid = 1;
         m_last_pat   = v;
         d = decode(v);
         if (d < 0) begin
            m_pe = 1;
            m_locked = 0;
         end else begin
            m_dv = 1;
            if (m_locked && d != m_exp) m_se = 1;
            m_digit  = d;
            m_locked = 1;
            m_exp    = (d >= WRAP) ? 0 : d + 1;
         end
      end
      if (clr) begin
         m_err8 = 0; m_err2 = 0;
      end else if (m_pe || m_se) begin
         if (m_err8 < 255) m_err8++;
         if (m_err2 < 3)   m_err2++;
      end
   endtask

   // One clock: drive inputs, update the model at the edge, compare mid-cycle.
   task automatic step(input logic [6:0] seg, input logic rst, input logic clr);
      seg_in = seg; reset = rst; clear = clr;
      @(posedge clk);
      model_update(seg, rst, clr);
      @(negedge clk);
      chk("digit",       32'(digit),       32'(m_digit));
      chk("digit_valid", 32'(digit_valid), 32'(m_dv));
      chk("pattern_err", 32'(pattern_err), 32'(m_pe));
      chk("seq_err",     32'(seq_err),     32'(m_se));
      chk("locked",      32'(locked),      32'(m_locked));
      chk("err_count",   32'(err_count),   32'(m_err8));
      chk("err_count_w2", 32'(err_count2), 32'(m_err2));
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [6:0] seg;
      int hold;
      int n_valid;
      int n_seq;
      int n_pat;
      int digit;
      bit locked;
      int err;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [6:0] seg, input int hold, input int nv,
                               input int ns, input int np, input int d,
                               input bit lk, input int e);
      vec_t r;
      r.seg = seg; r.hold = hold; r.n_valid = nv; r.n_seq = ns; r.n_pat = np;
      r.digit = d; r.locked = lk; r.err = e;
      return r;
   endfunction

   initial begin
      int nv, ns, np, first_evt, pulse_at;
      logic [6:0] p;
      int hold;
      bit clr, rst;

      // counting sequence 0..8 then wrap to 0
      tbl.push_back(mk(7'h3F, 20, 1, 0, 0, 0, 1, 0));
      tbl.push_back(mk(7'h06, 20, 1, 0, 0, 1, 1, 0));
      tbl.push_back(mk(7'h5B, 20, 1, 0, 0, 2, 1, 0));
      tbl.push_back(mk(7'h4F, 20, 1, 0, 0, 3, 1, 0));
      tbl.push_back(mk(7'h66, 20, 1, 0, 0, 4, 1, 0));
      tbl.push_back(mk(7'h6D, 20, 1, 0, 0, 5, 1, 0));
      tbl.push_back(mk(7'h7D, 20, 1, 0, 0, 6, 1, 0));
      tbl.push_back(mk(7'h07, 20, 1, 0, 0, 7, 1, 0));
      tbl.push_back(mk(7'h7F, 20, 1, 0, 0, 8, 1, 0));
      tbl.push_back(mk(7'h3F, 20, 1, 0, 0, 0, 1, 0));
      // short glitch is filtered; returning to the held pattern is not re-accepted
      tbl.push_back(mk(7'h06, 20, 1, 0, 0, 1, 1, 0));
      tbl.push_back(mk(7'h5B,  3, 0, 0, 0, 1, 1, 0));
      tbl.push_back(mk(7'h06, 20, 0, 0, 0, 1, 1, 0));
      tbl.push_back(mk(7'h5B, 20, 1, 0, 0, 2, 1, 0));
      // out-of-sequence digit resyncs
      tbl.push_back(mk(7'h4F, 20, 1, 0, 0, 3, 1, 0));
      tbl.push_back(mk(7'h6D, 20, 1, 1, 0, 5, 1, 1));
      tbl.push_back(mk(7'h7D, 20, 1, 0, 0, 6, 1, 1));
      // illegal pattern drops lock, digit holds
      tbl.push_back(mk(7'h49, 20, 0, 0, 1, 6, 0, 2));
      tbl.push_back(mk(7'h3F, 20, 1, 0, 0, 0, 1, 2));
      // digit above the wrap point is out of sequence, next expected is 0
      tbl.push_back(mk(7'h6F, 20, 1, 1, 0, 9, 1, 3));
      tbl.push_back(mk(7'h3F, 20, 1, 0, 0, 0, 1, 3));
      // illegal patterns pile up errors; narrow counter saturates
      tbl.push_back(mk(7'h49, 10, 0, 0, 1, 0, 0, 4));
      tbl.push_back(mk(7'h01, 10, 0, 0, 1, 0, 0, 5));
      tbl.push_back(mk(7'h49, 10, 0, 0, 1, 0, 0, 6));
      tbl.push_back(mk(7'h01, 10, 0, 0, 1, 0, 0, 7));
      tbl.push_back(mk(7'h49, 10, 0, 0, 1, 0, 0, 8));

      // reset, with the first pattern presented at release
      for (int i = 0; i < 3; i++) step(7'h00, 1'b1, 1'b0);
      chk("reset_digit",  32'(digit), 32'd0);
      chk("reset_locked", 32'(locked), 32'd0);
      chk("reset_err",    32'(err_count), 32'd0);

      foreach (tbl[t]) begin
         nv = 0; ns = 0; np = 0; first_evt = -1;
         for (int c = 0; c < tbl[t].hold; c++) begin
            step(tbl[t].seg, 1'b0, 1'b0);
            if (digit_valid) nv++;
            if (seq_err)     ns++;
            if (pattern_err) np++;
            if (first_evt < 0 && (digit_valid || seq_err || pattern_err)) first_evt = c;
         end
         $display("vec %0d seg=%02h hold=%0d valid=%0d seq=%0d pat=%0d digit=%0d locked=%0d err=%0d",
                  t, tbl[t].seg, tbl[t].hold, nv, ns, np, digit, locked, err_count);
         chk("tbl_n_valid", 32'(nv), 32'(tbl[t].n_valid));
         chk("tbl_n_seq",   32'(ns), 32'(tbl[t].n_seq));
         chk("tbl_n_pat",   32'(np), 32'(tbl[t].n_pat));
         chk("tbl_digit",   32'(digit), 32'(tbl[t].digit));
         chk("tbl_locked",  32'(locked), 32'(tbl[t].locked));
         chk("tbl_err",     32'(err_count), 32'(tbl[t].err));
         chk("tbl_err_w2",  32'(err_count2), 32'((tbl[t].err > 3) ? 3 : tbl[t].err));
         if (tbl[t].n_valid + tbl[t].n_seq + tbl[t].n_pat > 0)
            chk("tbl_latency", 32'(first_evt), 32'(2 + STABLE));
      end

      // clear coinciding with a seq_err event wins over the increment
      for (int c = 0; c < 12; c++) step(7'h3F, 1'b0, 1'b0);     // lock at 0, expect 1
      ns = 0;
      for (int c = 0; c < 20; c++) begin
         step(7'h66, 1'b0, (c >= 3 && c <= 9));
         if (seq_err) ns++;
      end
      $display("clear_vs_seq_err seq=%0d err=%0d err_w2=%0d digit=%0d", ns, err_count, err_count2, digit);
      chk("clr_seq_seen", 32'(ns), 32'd1);
      chk("clr_err",      32'(err_count), 32'd0);
      chk("clr_err_w2",   32'(err_count2), 32'd0);
      chk("clr_digit",    32'(digit), 32'd4);

      // reset mid-operation with 66 still present, then re-acquire
      step(7'h66, 1'b1, 1'b0);
      chk("midrst_digit",  32'(digit), 32'd0);
      chk("midrst_locked", 32'(locked), 32'd0);
      chk("midrst_pulses", 32'({digit_valid, seq_err, pattern_err}), 32'd0);
      pulse_at = -1;
      for (int c = 0; c < 12; c++) begin
         step(7'h66, 1'b0, 1'b0);
         if (digit_valid && pulse_at < 0) pulse_at = c;
         chk("midrst_no_seq_err", 32'(seq_err), 32'd0);
      end
      $display("reset_reacquire pulse_at=%0d digit=%0d locked=%0d", pulse_at, digit, locked);
      chk("midrst_latency", 32'(pulse_at), 32'(2 + STABLE));
      chk("midrst_digit4",  32'(digit), 32'd4);
      chk("midrst_locked1", 32'(locked), 32'd1);

      // randomized phases against the model
      for (int n = 0; n < 120; n++) begin
         if ($urandom_range(0, 9) < 7) begin
            if ($urandom_range(0, 1) == 1) p = PAT[(m_exp > 9) ? 0 : m_exp];
            else                           p = PAT[$urandom_range(0, 9)];
         end else begin
            p = 7'($urandom_range(0, 127));
         end
         hold = $urandom_range(1, 12);
         for (int c = 0; c < hold; c++) begin
            clr = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 199) == 0);
            step(p, rst, clr);
         end
         $display("rand %0d seg=%02h hold=%0d digit=%0d locked=%0d err=%0d",
                  n, p, hold, digit, locked, err_count);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
